key_g_pipe: RTL

- Parametrised AES key-schedule word transform: successor to the fixed single-lane g-function unit.
- Computes g(w) = SubWord(RotWord(w)) XOR {Rcon(round),24'h0} for the AES-128/192/256 schedules.
- Also computes the AES-256 SubWord-only step (i mod 8 == 4): no rotate, no Rcon.
- Configurable S-box lane count trades area for latency.
- Inputs are latched at start. Start/busy/done handshake supports back-to-back requests from the key-expansion controller.

---
 rtl/key_g_pipe.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/key_g_pipe.sv
// AES key-schedule g-function: SubWord(RotWord(w)) ^ {Rcon,24'h0}, or SubWord only.
// Latency: start sampled at edge k -> out_word/done valid after edge k+NSUB+2.
// Backpressure: none; start is ignored while busy, accepted again in IDLE or DONE.
//
// Ports: clk, n_rst (async active-low) | start, sub_only, in_word[31:0], round_num[3:0]
//        -> out_word[31:0] (held between completions), busy, done (1-cycle pulse).
module key_g_pipe #(
  parameter int LANES = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic        sub_only,
  input  logic [31:0] in_word,
  input  logic [3:0]  round_num,
  output logic [31:0] out_word,
  output logic        busy,
  output logic        done
);

  localparam int NSUB = 4 / LANES;

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("key_g_pipe: LANES must be 1, 2 or 4");
  end

  typedef enum logic [2:0] {IDLE, LOAD, SUB, RCON, DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_word;
  logic        r_sub_only;
  logic [3:0]  r_round;
  logic [31:0] r_tmp;
  logic [1:0]  r_cnt;
  logic [31:0] r_out;
  logic [7:0]  w_rcon;
  logic        w_accept;

  logic [1:0]  w_bidx   [LANES];
  logic [7:0]  w_sb_in  [LANES];
  logic [7:0]  w_sb_out [LANES];

  // A new request is only taken when no operation is in flight.
  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = LOAD;
      LOAD:    w_next = SUB;
      SUB:     if (r_cnt == 2'(NSUB - 1)) w_next = RCON;
      RCON:    w_next = DONE;
      DONE:    w_next = start ? LOAD : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_rcon = 8'h00;
    case (r_round)
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  // Lane l in substitution cycle c works on byte c*LANES+l, byte 0 being [7:0].
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_bidx[l]  = 2'(32'(r_cnt) * LANES + l);
    // S-box inputs are parked at zero outside SUB to keep them quiet.
    assign w_sb_in[l] = (r_state == SUB) ? r_tmp[{w_bidx[l], 3'b000} +: 8] : 8'h00;
    sbytes u_sbox (.i_byte(w_sb_in[l]), .o_byte(w_sb_out[l]));
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= IDLE;
      r_word     <= 32'h0;
      r_sub_only <= 1'b0;
      r_round    <= 4'h0;
      r_tmp      <= 32'h0;
      r_cnt      <= 2'd0;
      r_out      <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_word     <= in_word;
        r_sub_only <= sub_only;
        r_round    <= round_num;
      end
      case (r_state)
        LOAD: begin
          r_tmp <= r_sub_only ? r_word : {r_word[23:0], r_word[31:24]};
          r_cnt <= 2'd0;
        end
        SUB: begin
          for (int l = 0; l < LANES; l++) begin
            r_tmp[{w_bidx[l], 3'b000} +: 8] <= w_sb_out[l];
          end
          r_cnt <= r_cnt + 2'd1;
        end
        RCON: r_out <= r_tmp ^ (r_sub_only ? 32'h0 : {w_rcon, 24'h0});
        default: ;
      endcase
    end
  end

  assign out_word = r_out;
  assign busy     = (r_state == LOAD) || (r_state == SUB) || (r_state == RCON);
  assign done     = (r_state == DONE);

endmodule

// Combinational AES forward S-box, one byte in, one byte out.
// Latency: zero (pure lookup).
// Backpressure: not applicable.
module sbytes (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // Entry 0 sits in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign o_byte = SBOX[{~i_byte, 3'b000} +: 8];

endmodule
